// File: rtl/serial_adder.sv
// +------------------------------------------------------------------------+
// | serial_adder: bit-serial adder, one full_adder cell reused per clock   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_fa (
    .a     (sa[0]),
    .b     (sb[0]),
    .c_in  (cy),
    .sum   (fa_sum),
    .c_out (fa_carry)
  );

  // New bit enters at the MSB so bit i settles in acc[i] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_next = fa_sum;
    end else begin : g_acc_wide
      assign acc_next = {fa_sum, acc[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cy  <= c_in;
            cnt <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          acc <= acc_next;
          cy  <= fa_carry;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum   <= acc_next;
            c_out <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// +------------------------------------------------------------------------+
// | tb_serial_adder: randomized + directed check of serial_adder (W=8,4,1) |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       c_in;
  int         sel;

  logic       start8, start4, start1;
  logic       busy8, busy4, busy1;
  logic       done8, done4, done1;
  logic [7:0] sum8;
  logic [3:0] sum4;
  logic [0:0] sum1;
  logic       co8, co4, co1;

  logic        s_busy, s_done;
  logic [31:0] s_res;

  int vectors = 0;
  int miscompares = 0;
  int prev_res [9];

  always #5 clk = ~clk;

  assign start8 = start && (sel == 8);
  assign start4 = start && (sel == 4);
  assign start1 = start && (sel == 1);

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_in), .b(b_in), .c_in(c_in),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
  );
  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .a(a_in[3:0]), .b(b_in[3:0]), .c_in(c_in),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(co4)
  );
  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .a(a_in[0:0]), .b(b_in[0:0]), .c_in(c_in),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
  );

  always_comb begin
    s_busy = 1'b0;
    s_done = 1'b0;
    s_res  = '0;
    case (sel)
      8: begin s_busy = busy8; s_done = done8; s_res = {23'd0, co8, sum8}; end
      4: begin s_busy = busy4; s_done = done4; s_res = {27'd0, co4, sum4}; end
      1: begin s_busy = busy1; s_done = done1; s_res = {30'd0, co1, sum1}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (W=%0d): got %0d, expected %0d at %0t", tag, sel, got, exp, $time);
    end
  endtask

  // Called at a negedge while the selected DUT is IDLE or DONE; returns at the
  // negedge of the done cycle. inj>0 pulses start with junk operands in that RUN cycle.
  task automatic do_op(input int w, input int av, input int bv, input int cv, input int inj);
    int exp;
    exp   = (av + bv + cv) % (1 << (w + 1));
    sel   = w;
    a_in  = 8'(av);
    b_in  = 8'(bv);
    c_in  = cv[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= w; k++) begin
      if (k == inj) begin
        start = 1'b1;
        a_in  = 8'd99;
        b_in  = 8'd99;
      end
      check("busy_run", {31'd0, s_busy}, 32'd1);
      check("done_early", {31'd0, s_done}, 32'd0);
      check("result_held", s_res, prev_res[w]);
      @(negedge clk);
      start = 1'b0;
    end
    check("done_pulse", {31'd0, s_done}, 32'd1);
    check("busy_in_done", {31'd0, s_busy}, 32'd0);
    check("result", s_res, exp);
    prev_res[w] = exp;
  endtask

  task automatic expect_idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("idle_done", {31'd0, s_done}, 32'd0);
      check("idle_busy", {31'd0, s_busy}, 32'd0);
      check("idle_result", s_res, prev_res[sel]);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) prev_res[i] = 0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    c_in  = 1'b0;
    sel   = 8;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (prev_res[w]) begin
      if (w == 8 || w == 4 || w == 1) begin
        sel = w;
        #1;
        check("reset_busy", {31'd0, s_busy}, 32'd0);
        check("reset_done", {31'd0, s_done}, 32'd0);
        check("reset_result", s_res, 32'd0);
      end
    end
    sel = 8;

    // Directed WIDTH=8 cases
    do_op(8, 3, 5, 0, 0);     expect_idle(2);
    do_op(8, 255, 1, 0, 0);   expect_idle(1);
    do_op(8, 0, 0, 1, 0);     expect_idle(1);
    do_op(8, 255, 255, 1, 0); expect_idle(1);
    do_op(8, 10, 20, 0, 4);   expect_idle(3);

    // Abort mid-run: three RUN cycles then reset
    sel = 8; a_in = 8'd200; b_in = 8'd100; c_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_res[8] = 0; prev_res[4] = 0; prev_res[1] = 0;
    check("abort_busy", {31'd0, s_busy}, 32'd0);
    check("abort_done", {31'd0, s_done}, 32'd0);
    check("abort_result", s_res, 32'd0);
    expect_idle(12);
    do_op(8, 1, 2, 0, 0);

    // Back-to-back: start presented in the DONE cycle
    do_op(8, 7, 9, 1, 0);
    expect_idle(1);

    // Randomized WIDTH=8 traffic with mixed idle gaps and back-to-back starts
    for (int n = 0; n < 60; n++) begin
      do_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
      if ($urandom_range(0, 1) == 1) expect_idle(int'($urandom_range(1, 3)));
    end
    expect_idle(1);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      do_op(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0);
      check("popcount", s_res, 32'($countones(i)));
    end
    sel = 1; expect_idle(1);

    // WIDTH=4 exhaustive, alternating back-to-back and gapped starts
    for (int i = 0; i < 512; i++) begin
      do_op(4, (i >> 5) & 15, (i >> 1) & 15, i & 1, 0);
      if (i % 3 == 0) expect_idle(1);
    end
    expect_idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around one `full_adder` bit cell plus a carry flip-flop. Operands are loaded in parallel on a start pulse, added one bit per clock LSB-first, and the result is presented in parallel with a one-cycle done pulse. It sits directly downstream of `full_adder`, consuming its sum/carry each cycle, and is the next step after the purely combinational adder: the same cell reused over time instead of replicated in space.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- c_in  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse: `sum` and `c_out` are newly valid.
- sum  output  WIDTH  registered result; holds its value until the next completion or reset.
- c_out  output  1  registered final carry; holds with `sum`.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - `sa`: WIDTH-bit operand shift register.
  - `sb`: WIDTH-bit operand shift register.
  - `acc`: WIDTH-bit result shift register.
  - `cy`: 1-bit carry register.
  - `cnt`: bit counter, $clog2(WIDTH+1) bits, minimum 1.
- Bit cell: one `full_adder` instance with inputs `a=sa[0]`, `b=sb[0]`, `c_in=cy`. No other adder logic.
- **IDLE or DONE, start=1:** `sa<=a`, `sb<=b`, `cy<=c_in`, `cnt<=0`, `acc<=0`, next state RUN. Start is accepted in DONE as well, so back-to-back operations are allowed.
- **IDLE, start=0:** stay in IDLE.
- **DONE, start=0:** next state IDLE.
- **RUN, each edge:**
  - `sa<=sa>>1`, `sb<=sb>>1`.
  - `acc<={fa_sum, acc[WIDTH-1:1]}`, i.e. shift in at the MSB so that after WIDTH shifts bit i lands in `acc[i]`.
  - `cy<=fa_carry`.
  - `cnt<=cnt+1`.
- **RUN exit:** on the edge where `cnt==WIDTH-1`:
  - `sum<={fa_sum, acc[WIDTH-1:1]}` and `c_out<=fa_carry`, both loaded on that same edge;
  - next state DONE.
- **start while RUN:** ignored; no restart, no queueing.
- **Outputs by state:**
  - `busy=1` in RUN only.
  - `done=1` in DONE only; Moore outputs, registered or decoded from a state register.
- **Arithmetic:** `{c_out, sum} = a + b + c_in`, modulo 2^(WIDTH+1). There is no signed interpretation; the overflow information is carried in `c_out` only.
- **Reset (rst=1 at an edge):**
  - state<=IDLE;
  - `sum`, `c_out`, `acc`, `sa`, `sb`, `cy`, `cnt` all <=0;
  - `busy=0`, `done=0`.
  - Reset takes priority over start.
  - A reset during RUN aborts the operation with no `done` pulse.
- **WIDTH=1:** RUN lasts exactly one edge; the behaviour is otherwise identical.

## Timing
- Let edge E0 be the edge where start is accepted.
- RUN occupies the cycles after E0 through E_WIDTH, i.e. WIDTH cycles with `busy=1`.
- `done=1` in the single cycle following E_WIDTH; `sum`/`c_out` are valid from that cycle onward.
- Latency from the start edge to `done` is WIDTH+1 cycles.
- Throughput: one addition per WIDTH+1 cycles using back-to-back starts in DONE. Starting from IDLE it is one addition per WIDTH+2 cycles.
- `sum`/`c_out` do not change during RUN; the previous result stays visible until the new `done`.
- `a`, `b`, `c_in` only need to be valid on the accepting edge.

## Test plan
- **Basic add:** WIDTH=8, start with a=3, b=5, c_in=0 -> `busy` high 8 cycles, `done` pulse in the 9th cycle after E0, sum=8, c_out=0.
- **Carry chain:** WIDTH=8, a=255, b=1, c_in=0 -> sum=0, c_out=1. Then a=0, b=0, c_in=1 -> sum=1, c_out=0. Then a=255, b=255, c_in=1 -> sum=255, c_out=1.
- **Start during RUN:** WIDTH=8, a=10, b=20; pulse start=1 with a=99, b=99 at cycle 4 of RUN -> result is still sum=30, exactly one `done` pulse, timing unchanged.
- **Reset mid-operation:** WIDTH=8, a=200, b=100; assert rst at RUN cycle 3 -> next cycle state IDLE, busy=0, done=0, sum=0, c_out=0, no `done` pulse afterwards. A following start with a=1, b=2 -> sum=3.
- **Back-to-back:** WIDTH=8, assert start in the DONE cycle with a=7, b=9, c_in=1 -> first result is held until the second `done` exactly 9 cycles later; second result sum=17, c_out=0.
- **Exhaustive small width:** WIDTH=1, loop i=0..7 applying {a, b, c_in}=i -> each `done` cycle has {c_out, sum} equal to the popcount of i. WIDTH=4: all 512 operand/carry combinations are checked against a+b+c_in.
